// File: rtl/conv_pkg.sv
// Shared constants for the 3x3 convolution engine, its controller and the result writer.
`default_nettype none

package conv_pkg;

   localparam int IMG_W_DEF = 128;
   localparam int IMG_H_DEF = 128;
   localparam int PIX_W     = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

`default_nettype wire

// File: rtl/pix_saturate.sv
// Shift, clamp and saturation flag for one convolution result.
// Optional build macro: CONV_WR_ABS_EN (pixel becomes min(|s|, 255)).
`default_nettype none

module pix_saturate
   import conv_pkg::*;
#(
   parameter int DW_IN = 24,
   parameter int SHIFT = 0
) (
   input  logic [DW_IN-1:0] result_i,
   output logic [PIX_W-1:0] pix_o,
   output logic             sat_o
);

   localparam logic signed [DW_IN-1:0] PIX_MAX = DW_IN'(255);

   logic signed [DW_IN-1:0] s;

   assign s = $signed(result_i) >>> SHIFT;

`ifdef CONV_WR_ABS_EN
   // One extra bit so that negating the most negative value cannot overflow.
   logic [DW_IN:0] mag;

   always_comb begin
      mag   = s[DW_IN-1] ? (~{s[DW_IN-1], s} + (DW_IN+1)'(1)) : {1'b0, s};
      pix_o = mag[PIX_W-1:0];
      sat_o = 1'b0;
      if (mag > (DW_IN+1)'(255)) begin
         pix_o = '1;
         sat_o = 1'b1;
      end
   end
`else
   always_comb begin
      pix_o = s[PIX_W-1:0];
      sat_o = 1'b0;
      if (s[DW_IN-1]) begin
         pix_o = '0;
         sat_o = 1'b1;
      end else if (s > PIX_MAX) begin
         pix_o = '1;
         sat_o = 1'b1;
      end
   end
`endif

endmodule

`default_nettype wire

// File: rtl/conv_result_writer.sv
// Captures each done_conv rising edge, clamps the result and writes it in raster order.
// Optional build macro: CONV_WR_ABS_EN (absolute-value pixel mode in pix_saturate).
`default_nettype none

module conv_result_writer
   import conv_pkg::*;
#(
   parameter int IMG_W  = IMG_W_DEF,
   parameter int IMG_H  = IMG_H_DEF,
   parameter int DW_IN  = 24,
   parameter int SHIFT  = 0,
   parameter int ADDR_W = $clog2(IMG_W*IMG_H)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              done_conv,
   input  logic [DW_IN-1:0]  result,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [PIX_W-1:0]  wr_data,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] sat_count
);

   localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(IMG_W*IMG_H-1);

   state_e              state_q, state_d;
   logic                dc_q;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic [ADDR_W-1:0]   sat_q, sat_d;
   logic                wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [PIX_W-1:0]    wr_data_q, wr_data_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic                cap;
   logic [PIX_W-1:0]    pix;
   logic                pix_sat;

   assign cap = done_conv & ~dc_q;

   pix_saturate #(
      .DW_IN (DW_IN),
      .SHIFT (SHIFT)
   ) u_sat (
      .result_i (result),
      .pix_o    (pix),
      .sat_o    (pix_sat)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         dc_q      <= 1'b0;
         cnt_q     <= '0;
         sat_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         dc_q      <= done_conv;
         cnt_q     <= cnt_d;
         sat_q     <= sat_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sat_d     = sat_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;

      case (state_q)
         // A capture coinciding with start is deliberately dropped here.
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_RUN;
               cnt_d   = '0;
               sat_d   = '0;
            end
         end
         ST_RUN: begin
            if (cap) begin
               wr_en_d   = 1'b1;
               wr_addr_d = cnt_q;
               wr_data_d = pix;
               if (pix_sat && (sat_q != '1))
                  sat_d = sat_q + ADDR_W'(1);
               if (cnt_q == LAST_PIX)
                  state_d = ST_DONE;
               else
                  cnt_d = cnt_q + ADDR_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
   end

   assign wr_en     = wr_en_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign sat_count = sat_q;

endmodule

`default_nettype wire
